// File: rtl/aes_decrypt_iter_if.sv
// Handshake bundle joining the AES decrypt core to its key/ciphertext source
// and to the plaintext sink.
interface aes_decrypt_iter_if #(
  parameter int Nk = 4
);
  logic             key_load;
  logic [Nk*32-1:0] key;
  logic             key_ready;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             busy;

  modport master (
    output key_load, key, in_valid, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  key_load, key, in_valid, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: sequential key expansion into a round-key
// buffer, then one inverse round per clock for each accepted block.
module aes_decrypt_iter #(
  parameter int Nk = 4
) (
  input logic               clk,
  input logic               rst_n,
  aes_decrypt_iter_if.slave bus
);
  localparam int Nr = Nk + 6;
  localparam int NW = 4 * (Nr + 1);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_decrypt_iter: Nk must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_ROUND, S_OUT} state_t;

  state_t       r_state;
  logic [31:0]  r_w [NW];
  logic [127:0] r_data;
  logic [5:0]   r_widx;
  logic [2:0]   r_kmod;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic         r_key_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic         w_key_accept;
  logic         w_in_ready;
  logic [31:0]  w_t;
  logic [31:0]  w_new_word;
  logic [127:0] w_rk;
  logic [127:0] w_rk_last;
  logic [127:0] w_inv;
  logic [127:0] w_round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte (row r, column c) lives at index 4c+r counted from the MSB
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign w_key_accept = bus.key_load && (r_state == S_IDLE || r_state == S_EXPAND);
  assign w_in_ready   = (r_state == S_IDLE) && r_key_ready && !bus.key_load;

  // r_kmod tracks i mod Nk and r_rcon the matching round constant, so no divider is needed
  always_comb begin
    w_t = r_w[r_widx - 6'd1];
    if (r_kmod == 3'd0) begin
      w_t = sub_word({w_t[23:0], w_t[31:24]}) ^ {r_rcon, 24'h0};
    end else if (Nk == 8 && r_kmod == 3'd4) begin
      w_t = sub_word(w_t);
    end
    w_new_word = r_w[r_widx - 6'(Nk)] ^ w_t;
  end

  assign w_rk        = {r_w[{r_round, 2'b00}], r_w[{r_round, 2'b01}],
                        r_w[{r_round, 2'b10}], r_w[{r_round, 2'b11}]};
  assign w_rk_last   = {r_w[4*Nr], r_w[4*Nr+1], r_w[4*Nr+2], r_w[4*Nr+3]};
  assign w_inv       = inv_shift_sub(r_data) ^ w_rk;
  assign w_round_out = (r_round == 4'd0) ? w_inv : inv_mix(w_inv);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_widx      <= '0;
      r_kmod      <= '0;
      r_rcon      <= '0;
      r_round     <= '0;
      r_key_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int j = 0; j < NW; j++) r_w[j] <= '0;
    end else if (w_key_accept) begin
      for (int j = 0; j < Nk; j++) r_w[j] <= bus.key[(Nk-1-j)*32 +: 32];
      r_widx      <= 6'(Nk);
      r_kmod      <= 3'd0;
      r_rcon      <= 8'h01;
      r_key_ready <= 1'b0;
      r_busy      <= 1'b1;
      r_state     <= S_EXPAND;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && w_in_ready) begin
            r_data  <= bus.in_data ^ w_rk_last;
            r_round <= 4'(Nr - 1);
            r_busy  <= 1'b1;
            r_state <= S_ROUND;
          end
        end
        S_EXPAND: begin
          r_w[r_widx] <= w_new_word;
          r_widx      <= r_widx + 6'd1;
          r_kmod      <= (r_kmod == 3'(Nk - 1)) ? 3'd0 : r_kmod + 3'd1;
          if (r_kmod == 3'd0) r_rcon <= xtime(r_rcon);
          if (r_widx == 6'(NW - 1)) begin
            r_key_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_ROUND: begin
          r_data <= w_round_out;
          if (r_round == 4'd0) begin
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_OUT;
          end else begin
            r_round <= r_round - 4'd1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.key_ready = r_key_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_data;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter: AES-128 core exercised in depth,
// AES-192 and AES-256 cores checked against the FIPS-197 vectors.
module tb_aes_decrypt_iter;
  localparam logic [255:0] KEY128  = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY128B = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY192  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTALL   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTB     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PTB     = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk;
  logic rst_n;

  logic         keyLoad  [3];
  logic [255:0] keyVal   [3];
  logic         inValid  [3];
  logic [127:0] inData   [3];
  logic         outReady [3];
  logic         keyReady [3];
  logic         inReady  [3];
  logic         outValid [3];
  logic [127:0] outData  [3];
  logic         busyOut  [3];

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [127:0] q2[$];

  int checks = 0;
  int errors = 0;

  aes_decrypt_iter_if #(.Nk(4)) bus4 ();
  aes_decrypt_iter_if #(.Nk(6)) bus6 ();
  aes_decrypt_iter_if #(.Nk(8)) bus8 ();

  aes_decrypt_iter #(.Nk(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  aes_decrypt_iter #(.Nk(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
  aes_decrypt_iter #(.Nk(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  assign bus4.key_load  = keyLoad[0];
  assign bus4.key       = keyVal[0][127:0];
  assign bus4.in_valid  = inValid[0];
  assign bus4.in_data   = inData[0];
  assign bus4.out_ready = outReady[0];
  assign keyReady[0]    = bus4.key_ready;
  assign inReady[0]     = bus4.in_ready;
  assign outValid[0]    = bus4.out_valid;
  assign outData[0]     = bus4.out_data;
  assign busyOut[0]     = bus4.busy;

  assign bus6.key_load  = keyLoad[1];
  assign bus6.key       = keyVal[1][191:0];
  assign bus6.in_valid  = inValid[1];
  assign bus6.in_data   = inData[1];
  assign bus6.out_ready = outReady[1];
  assign keyReady[1]    = bus6.key_ready;
  assign inReady[1]     = bus6.in_ready;
  assign outValid[1]    = bus6.out_valid;
  assign outData[1]     = bus6.out_data;
  assign busyOut[1]     = bus6.busy;

  assign bus8.key_load  = keyLoad[2];
  assign bus8.key       = keyVal[2];
  assign bus8.in_valid  = inValid[2];
  assign bus8.in_data   = inData[2];
  assign bus8.out_ready = outReady[2];
  assign keyReady[2]    = bus8.key_ready;
  assign inReady[2]     = bus8.in_ready;
  assign outValid[2]    = bus8.out_valid;
  assign outData[2]     = bus8.out_data;
  assign busyOut[2]     = bus8.busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int qSize(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pushExp(input int sel, input logic [127:0] pt);
    case (sel)
      0:       q0.push_back(pt);
      1:       q1.push_back(pt);
      default: q2.push_back(pt);
    endcase
  endtask

  // Plaintext is compared at the falling edge of each output handshake cycle
  always @(negedge clk) begin
    if (rst_n && outValid[0] && outReady[0]) begin
      if (q0.size() != 0) checkOutput("data128", outData[0], q0.pop_front());
      else checkOutput("spurious128", outValid[0], 1'b0);
    end
    if (rst_n && outValid[1] && outReady[1]) begin
      if (q1.size() != 0) checkOutput("data192", outData[1], q1.pop_front());
      else checkOutput("spurious192", outValid[1], 1'b0);
    end
    if (rst_n && outValid[2] && outReady[2]) begin
      if (q2.size() != 0) checkOutput("data256", outData[2], q2.pop_front());
      else checkOutput("spurious256", outValid[2], 1'b0);
    end
  end

  task automatic loadKey(input int sel, input logic [255:0] k, input int expLat);
    int n;
    keyVal[sel]  = k;
    keyLoad[sel] = 1'b1;
    @(posedge clk); #1;
    keyLoad[sel] = 1'b0;
    checkOutput("expandBusy", busyOut[sel], 1'b1);
    checkOutput("expandKeyCleared", keyReady[sel], 1'b0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!keyReady[sel] && n < 200);
    checkOutput("keyLatency", n, expLat);
  endtask

  task automatic applyStimulus(input int sel, input logic [127:0] ct, input logic [127:0] pt,
                               input int expLat);
    int n;
    n = 0;
    while (!inReady[sel] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("inReadyWait", inReady[sel], 1'b1);
    inValid[sel] = 1'b1;
    inData[sel]  = ct;
    pushExp(sel, pt);
    @(posedge clk); #1;
    inValid[sel] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!outValid[sel] && n < 100);
    checkOutput("decryptLatency", n, expLat);
  endtask

  task automatic waitDrain(input int sel);
    int n;
    n = 0;
    while (qSize(sel) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", qSize(sel), 0);
  endtask

  initial begin
    int first;
    int second;
    int accepts;
    int n;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      keyLoad[s]  = 1'b0;
      keyVal[s]   = '0;
      inValid[s]  = 1'b0;
      inData[s]   = '0;
      outReady[s] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checkOutput("rstKeyReady", keyReady[s], 1'b0);
      checkOutput("rstInReady", inReady[s], 1'b0);
      checkOutput("rstOutValid", outValid[s], 1'b0);
      checkOutput("rstBusy", busyOut[s], 1'b0);
      checkOutput("rstOutData", outData[s], '0);
    end
    rst_n = 1'b1;

    // Blocks offered before any key is loaded must be refused
    inValid[0] = 1'b1;
    inData[0]  = CT128;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("noKeyInReady", inReady[0], 1'b0);
      checkOutput("noKeyOutValid", outValid[0], 1'b0);
    end
    inValid[0] = 1'b0;

    loadKey(0, KEY128, 40);
    applyStimulus(0, CT128, PTALL, 10);
    waitDrain(0);

    // Backpressure, with a key_load in OUT that must be ignored
    outReady[0] = 1'b0;
    applyStimulus(0, CT128, PTALL, 10);
    for (int c = 0; c < 20; c++) begin
      keyLoad[0] = (c == 5);
      if (c == 5) keyVal[0] = KEY128B;
      @(posedge clk); #1;
      checkOutput("bpData", outData[0], PTALL);
      checkOutput("bpValid", outValid[0], 1'b1);
      checkOutput("bpInReady", inReady[0], 1'b0);
    end
    keyLoad[0] = 1'b0;
    checkOutput("bpKeyReady", keyReady[0], 1'b1);
    outReady[0] = 1'b1;
    waitDrain(0);
    applyStimulus(0, CT128, PTALL, 10);
    waitDrain(0);

    // key_load beats in_valid, then a second key_load restarts expansion
    keyVal[0]  = KEY128;
    keyLoad[0] = 1'b1;
    inValid[0] = 1'b1;
    inData[0]  = CT128;
    #1;
    checkOutput("priorityInReady", inReady[0], 1'b0);
    @(posedge clk); #1;
    keyLoad[0] = 1'b0;
    inValid[0] = 1'b0;
    checkOutput("restartBusy", busyOut[0], 1'b1);
    repeat (5) @(posedge clk);
    #1;
    loadKey(0, KEY128B, 40);
    applyStimulus(0, CTB, PTB, 10);
    waitDrain(0);

    // Throughput with in_valid held and out_ready high
    inValid[0] = 1'b1;
    inData[0]  = CTB;
    accepts = 0;
    first   = 0;
    second  = 0;
    for (int c = 0; c < 60 && accepts < 2; c++) begin
      if (inReady[0]) begin
        pushExp(0, PTB);
        if (accepts == 0) first = c;
        else second = c;
        accepts++;
      end
      @(posedge clk); #1;
    end
    inValid[0] = 1'b0;
    checkOutput("throughputPeriod", second - first, 12);
    waitDrain(0);

    // key_load during ROUND is ignored
    n = 0;
    while (!inReady[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    inValid[0] = 1'b1;
    inData[0]  = CTB;
    pushExp(0, PTB);
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    keyVal[0]  = KEY128;
    keyLoad[0] = 1'b1;
    @(posedge clk); #1;
    keyLoad[0] = 1'b0;
    checkOutput("roundBusy", busyOut[0], 1'b1);
    checkOutput("roundKeyReady", keyReady[0], 1'b1);
    waitDrain(0);
    checkOutput("keptKeyReady", keyReady[0], 1'b1);
    applyStimulus(0, CTB, PTB, 10);
    waitDrain(0);

    loadKey(1, KEY192, 46);
    applyStimulus(1, CT192, PTALL, 12);
    waitDrain(1);
    loadKey(2, KEY256, 52);
    applyStimulus(2, CT256, PTALL, 14);
    waitDrain(2);

    // One-cycle reset in the middle of a decryption
    inValid[0] = 1'b1;
    inData[0]  = CTB;
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midRstOutValid", outValid[0], 1'b0);
    checkOutput("midRstKeyReady", keyReady[0], 1'b0);
    checkOutput("midRstInReady", inReady[0], 1'b0);
    checkOutput("midRstOutData", outData[0], '0);
    checkOutput("midRstBusy", busyOut[0], 1'b0);
    inValid[0] = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      checkOutput("postRstInReady", inReady[0], 1'b0);
      checkOutput("postRstOutValid", outValid[0], 1'b0);
    end
    inValid[0] = 1'b0;
    loadKey(0, KEY128B, 40);
    applyStimulus(0, CTB, PTB, 10);
    waitDrain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
